// File: rtl/ars_pkg.sv
// Shared definitions for the AES MixColumns/AddRoundKey stage: FSM states,
// GF(2^8) helpers and state byte/column slicing for the 128-bit layout
// (byte0 = [127:120], column c = [127-32c -: 32], row r = byte 4c+r).
package ars_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_COL0 = 3'd1,
      ST_COL1 = 3'd2,
      ST_COL2 = 3'd3,
      ST_COL3 = 3'd4
   } ars_state_t;

   localparam logic [7:0] GF_02 = 8'h02;
   localparam logic [7:0] GF_03 = 8'h03;
   localparam logic [7:0] GF_09 = 8'h09;
   localparam logic [7:0] GF_0B = 8'h0b;
   localparam logic [7:0] GF_0D = 8'h0d;
   localparam logic [7:0] GF_0E = 8'h0e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by one of the fixed MixColumns coefficients via repeated xtime
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (c)
         GF_02:   return x2;
         GF_03:   return x2 ^ b;
         GF_09:   return x8 ^ b;
         GF_0B:   return x8 ^ x2 ^ b;
         GF_0D:   return x8 ^ x4 ^ b;
         GF_0E:   return x8 ^ x4 ^ x2;
         default: return b;
      endcase
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] col, input logic [1:0] r);
      return col[31 - 8*r -: 8];
   endfunction

   function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
      return s[127 - 32*c -: 32];
   endfunction

   // Return s with column c replaced by v
   function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                            input logic [31:0] v);
      logic [127:0] r;
      r = s;
      r[127 - 32*c -: 32] = v;
      return r;
   endfunction

endpackage

// File: rtl/ars_mixcol_column.sv
// Combinational single-column (Inv)MixColumns. The inverse matrix only exists
// when ARS_MIXCOL_DECRYPT_EN is defined; otherwise inv_i is ignored.
module ars_mixcol_column
   import ars_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        inv_i,
   output logic [31:0] col_o
);

   logic [7:0] a0, a1, a2, a3;
   logic [31:0] fwd;

   assign a0 = get_byte(col_i, 2'd0);
   assign a1 = get_byte(col_i, 2'd1);
   assign a2 = get_byte(col_i, 2'd2);
   assign a3 = get_byte(col_i, 2'd3);

   assign fwd = {gf_mul(a0, GF_02) ^ gf_mul(a1, GF_03) ^ a2 ^ a3,
                 a0 ^ gf_mul(a1, GF_02) ^ gf_mul(a2, GF_03) ^ a3,
                 a0 ^ a1 ^ gf_mul(a2, GF_02) ^ gf_mul(a3, GF_03),
                 gf_mul(a0, GF_03) ^ a1 ^ a2 ^ gf_mul(a3, GF_02)};

`ifdef ARS_MIXCOL_DECRYPT_EN
   logic [31:0] inv;

   assign inv = {gf_mul(a0, GF_0E) ^ gf_mul(a1, GF_0B) ^ gf_mul(a2, GF_0D) ^ gf_mul(a3, GF_09),
                 gf_mul(a0, GF_09) ^ gf_mul(a1, GF_0E) ^ gf_mul(a2, GF_0B) ^ gf_mul(a3, GF_0D),
                 gf_mul(a0, GF_0D) ^ gf_mul(a1, GF_09) ^ gf_mul(a2, GF_0E) ^ gf_mul(a3, GF_0B),
                 gf_mul(a0, GF_0B) ^ gf_mul(a1, GF_0D) ^ gf_mul(a2, GF_09) ^ gf_mul(a3, GF_0E)};

   assign col_o = inv_i ? inv : fwd;
`else
   logic unused_inv;
   assign unused_inv = inv_i;
   assign col_o = fwd;
`endif

endmodule

// File: rtl/ars_mixcolumns.sv
// Iterative AES MixColumns + AddRoundKey, one column per clock (4-cycle
// latency, 5-cycle throughput). Define ARS_MIXCOL_DECRYPT_EN to enable the
// inverse path; without it decrypt_i is ignored and every op is forward.
module ars_mixcolumns
   import ars_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic         decrypt_i,
   input  logic         last_round_i,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic         ready_o,
   output logic [127:0] data_o
);

   ars_state_t   state;
   logic [127:0] data_reg, key_reg;
   logic [1:0]   mode_reg;      // {decrypt, last_round}
   logic         dec_in;
   logic [1:0]   col_idx;
   logic [31:0]  cur_col, key_col, mixed_col, new_col;

`ifdef ARS_MIXCOL_DECRYPT_EN
   assign dec_in = decrypt_i;
`else
   logic unused_decrypt;
   assign unused_decrypt = decrypt_i;
   assign dec_in = 1'b0;
`endif

   // COL0..COL3 map onto column 0..3; the IDLE value is never written back
   assign col_idx = 2'(state - ST_COL0);
   assign cur_col = get_col(data_reg, col_idx);
   assign key_col = get_col(key_reg, col_idx);

   ars_mixcol_column u_col (
      .col_i (cur_col),
      .inv_i (mode_reg[1]),
      .col_o (mixed_col)
   );

   // Decrypt already XORed the key in at load time, so only encrypt adds it here
   always_comb begin
      new_col = mixed_col;
      case (mode_reg)
         2'b00:   new_col = mixed_col ^ key_col;
         2'b10:   new_col = mixed_col;
         2'b01:   new_col = cur_col ^ key_col;
         2'b11:   new_col = cur_col;
         default: new_col = mixed_col;
      endcase
   end

   // FSM: load on start in IDLE, then rewrite one column per cycle in place
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         data_reg <= '0;
         key_reg  <= '0;
         mode_reg <= '0;
         ready_o  <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  data_reg <= dec_in ? (data_i ^ key_i) : data_i;
                  key_reg  <= key_i;
                  mode_reg <= {dec_in, last_round_i};
                  state    <= ST_COL0;
               end
            end
            ST_COL0: begin
               data_reg <= put_col(data_reg, col_idx, new_col);
               state    <= ST_COL1;
            end
            ST_COL1: begin
               data_reg <= put_col(data_reg, col_idx, new_col);
               state    <= ST_COL2;
            end
            ST_COL2: begin
               data_reg <= put_col(data_reg, col_idx, new_col);
               state    <= ST_COL3;
            end
            ST_COL3: begin
               data_reg <= put_col(data_reg, col_idx, new_col);
               ready_o  <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign data_o = data_reg;

endmodule

// File: tb/tb_ars_mixcolumns.sv
// Self-checking bench for ars_mixcolumns: directed vector table, random ops
// against a matrix-level AES reference model, and multi-cycle corner cases.
module tb_ars_mixcolumns;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start_i = 1'b0;
   logic         decrypt_i = 1'b0;
   logic         last_round_i = 1'b0;
   logic [127:0] data_i = '0;
   logic [127:0] key_i = '0;
   logic         ready_o;
   logic [127:0] data_o;

   int total = 0;
   int bad = 0;

   ars_mixcolumns dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .decrypt_i    (decrypt_i),
      .last_round_i (last_round_i),
      .data_i       (data_i),
      .key_i        (key_i),
      .ready_o      (ready_o),
      .data_o       (data_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        nm;
      logic [127:0] d;
      logic [127:0] k;
      logic         dec;
      logic         last;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[5];

   // Shift-and-add GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // AES round-stage reference: circulant matrix over each column
   function automatic logic [127:0] ref_model(input logic [127:0] d, input logic [127:0] k,
                                              input logic dec, input logic last);
      logic [7:0]   fc[4] = '{8'h02, 8'h03, 8'h01, 8'h01};
      logic [7:0]   ic[4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] s, o;
      logic [7:0]   acc;
      logic         eff_dec;
`ifdef ARS_MIXCOL_DECRYPT_EN
      eff_dec = dec;
`else
      eff_dec = 1'b0;
`endif
      if (last) return d ^ k;
      s = eff_dec ? (d ^ k) : d;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(eff_dec ? ic[(j - r + 4) % 4] : fc[(j - r + 4) % 4],
                           s[127 - 8*(4*c + j) -: 8]);
            o[127 - 8*(4*c + r) -: 8] = acc;
         end
      return eff_dec ? o : (o ^ k);
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Launch one op from IDLE, scramble inputs after the start edge, then check
   // latency, result and that ready is a single-cycle pulse
   task automatic run_op(input string nm, input logic [127:0] d, input logic [127:0] k,
                         input logic dec, input logic last, input logic [127:0] exp);
      int lat;
      data_i = d; key_i = k; decrypt_i = dec; last_round_i = last; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      data_i = {$urandom, $urandom, $urandom, $urandom};
      key_i  = {$urandom, $urandom, $urandom, $urandom};
      decrypt_i = 1'($urandom);
      last_round_i = 1'($urandom);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            lat = i;
            break;
         end
      end
      chk({nm, " latency"}, 128'(lat), 128'd4);
      chk({nm, " data"}, data_o, exp);
      @(posedge clk); #1;
      chk({nm, " ready pulse width"}, 128'(ready_o), 128'd0);
      chk({nm, " hold"}, data_o, exp);
   endtask

   initial begin
      logic [127:0] d, k, first_exp;
      logic dec, last;
      int seen;

      vecs[0] = '{"fwd key0", 128'hdb135345_f20a225c_01010101_d4d4d4d5, 128'h0, 1'b0, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6};
`ifdef ARS_MIXCOL_DECRYPT_EN
      vecs[1] = '{"inv key0", 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b1, 1'b0,
                  128'hdb135345_f20a225c_01010101_d4d4d4d5};
`else
      vecs[1] = '{"inv key0 (fwd build)", 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b1,
                  1'b0, ref_model(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b0, 1'b0)};
`endif
      vecs[2] = '{"last fwd", 128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b0, 1'b1,
                  128'hffeeddcc_bbaa9988_77665544_33221100};
      vecs[3] = '{"last inv", 128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1, 1'b1,
                  128'hffeeddcc_bbaa9988_77665544_33221100};
      vecs[4] = '{"fwd key", 128'hc6c6c6c6_2d26314c_00000000_00000000,
                  128'h00000001_00000000_00000000_000000ff, 1'b0, 1'b0,
                  128'hc6c6c6c7_4d7ebdf8_00000000_000000ff};

      // Reset state
      #12;
      chk("reset ready", 128'(ready_o), 128'd0);
      chk("reset data", data_o, 128'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].d, vecs[i].k, vecs[i].dec, vecs[i].last, vecs[i].exp);

      // Random ops against the reference model
      for (int n = 0; n < 24; n++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         dec = 1'($urandom);
         last = ($urandom_range(0, 3) == 0);
         run_op($sformatf("rand%0d", n), d, k, dec, last, ref_model(d, k, dec, last));
      end

      // Start re-pulsed mid-operation must be ignored
      d = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      k = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
      first_exp = ref_model(d, k, 1'b0, 1'b0);
      data_i = d; key_i = k; decrypt_i = 1'b0; last_round_i = 1'b0; start_i = 1'b1;
      @(posedge clk); #1;                       // edge k
      start_i = 1'b0;
      @(posedge clk); #1;                       // edge k+1
      data_i = ~d; key_i = ~k; start_i = 1'b1;  // sampled at k+2
      @(posedge clk); #1;
      start_i = 1'b0;
      seen = 0;
      for (int i = 3; i <= 12; i++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            seen++;
            chk("midstart ready edge", 128'(i), 128'd4);
            chk("midstart data", data_o, first_exp);
         end
      end
      chk("midstart pulse count", 128'(seen), 128'd1);

      // Reset mid-operation discards it
      data_i = d; key_i = k; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;                       // after edge k+2
      reset = 1'b0;
      #1;
      chk("midreset data", data_o, 128'd0);
      chk("midreset ready", 128'(ready_o), 128'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ready_o) seen++;
      end
      chk("midreset no pulse", 128'(seen), 128'd0);
      chk("midreset data held", data_o, 128'd0);
      run_op("after reset", d, k, 1'b0, 1'b0, first_exp);

      // start held high: ready every 5 cycles
      data_i = d; key_i = k; decrypt_i = 1'b0; last_round_i = 1'b0; start_i = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b ready c%0d", c), 128'(ready_o), 128'((c % 5) == 4));
         if ((c % 5) == 4) chk($sformatf("b2b data c%0d", c), data_o, first_exp);
      end
      start_i = 1'b0;
      repeat (6) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
